// File: rtl/mem_arbiter_if.sv
// Bus bundle for the MEM/fetch arbiter: both requester ports plus the
// shared SRAM controller port. The slave modport is the arbiter's view,
// the master modport is the environment's view (requesters and SRAM).
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m_r_en;
  logic              m_w_en;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ready;

  logic              i_r_en;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;

  logic              sram_r_en;
  logic              sram_w_en;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
  logic              sram_ready;

  logic              grant_mem;

  modport slave (
    input  m_r_en, m_w_en, m_addr, m_wdata,
    output m_rdata, m_ready,
    input  i_r_en, i_addr,
    output i_rdata, i_ready,
    output sram_r_en, sram_w_en, sram_addr, sram_wdata,
    input  sram_rdata, sram_ready,
    output grant_mem
  );

  modport master (
    output m_r_en, m_w_en, m_addr, m_wdata,
    input  m_rdata, m_ready,
    output i_r_en, i_addr,
    input  i_rdata, i_ready,
    input  sram_r_en, sram_w_en, sram_addr, sram_wdata,
    output sram_rdata, sram_ready,
    input  grant_mem
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (MEM stage, instruction fetch) in front of a single
// SRAM controller. One command outstanding at a time; ties alternate.
//
//   state | meaning
//   IDLE  | no command outstanding, arbitrate on each edge
//   SERVE | command driven to SRAM, waiting for sram_ready pulse
//   DONE  | owner's ready high for this cycle, owner becomes last_owner
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_owner_mem;
  logic              r_last_mem;
  logic              r_op_wr;
  logic              r_sram_r_en;
  logic              r_sram_w_en;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [DATA_W-1:0] r_sram_wdata;
  logic [DATA_W-1:0] r_m_rdata;
  logic [DATA_W-1:0] r_i_rdata;

  logic              w_m_req;
  logic              w_i_req;
  logic              w_pick_mem;

  assign w_m_req = bus.m_r_en | bus.m_w_en;
  assign w_i_req = bus.i_r_en;
  // On a tie the requester that did not win last time gets the grant.
  assign w_pick_mem = w_m_req & (~w_i_req | ~r_last_mem);

  // Arbitration FSM with latched SRAM command and per-requester read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_owner_mem  <= 1'b1;
      r_last_mem   <= 1'b0;
      r_op_wr      <= 1'b0;
      r_sram_r_en  <= 1'b0;
      r_sram_w_en  <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_m_rdata    <= '0;
      r_i_rdata    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_m_req | w_i_req) begin
            r_owner_mem <= w_pick_mem;
            r_state     <= ST_SERVE;
            if (w_pick_mem) begin
              // Read and write together is a write.
              r_sram_addr  <= bus.m_addr;
              r_sram_wdata <= bus.m_wdata;
              r_op_wr      <= bus.m_w_en;
              r_sram_w_en  <= bus.m_w_en;
              r_sram_r_en  <= ~bus.m_w_en;
            end else begin
              r_sram_addr <= bus.i_addr;
              r_op_wr     <= 1'b0;
              r_sram_w_en <= 1'b0;
              r_sram_r_en <= 1'b1;
            end
          end
        end
        ST_SERVE: begin
          if (bus.sram_ready) begin
            r_sram_r_en <= 1'b0;
            r_sram_w_en <= 1'b0;
            r_state     <= ST_DONE;
            // A requester that withdrew mid-transaction does not get data.
            if (!r_op_wr) begin
              if (r_owner_mem && bus.m_r_en) begin
                r_m_rdata <= bus.sram_rdata;
              end else if (!r_owner_mem && bus.i_r_en) begin
                r_i_rdata <= bus.sram_rdata;
              end
            end
          end
        end
        ST_DONE: begin
          r_last_mem <= r_owner_mem;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.m_ready    = ~w_m_req | ((r_state == ST_DONE) & r_owner_mem);
  assign bus.i_ready    = ~w_i_req | ((r_state == ST_DONE) & ~r_owner_mem);
  assign bus.m_rdata    = r_m_rdata;
  assign bus.i_rdata    = r_i_rdata;
  assign bus.sram_r_en  = r_sram_r_en;
  assign bus.sram_w_en  = r_sram_w_en;
  assign bus.sram_addr  = r_sram_addr;
  assign bus.sram_wdata = r_sram_wdata;
  assign bus.grant_mem  = r_owner_mem;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural SRAM responder.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  int          lat_cfg   = 0;
  logic [31:0] rdata_cfg = '0;
  int          log_n     = 0;
  logic        log_mem   [64];
  logic        log_wr    [64];
  logic [31:0] log_addr  [64];
  logic [31:0] log_wdata [64];
  int          overlap_n  = 0;
  int          rd_seen    = 0;
  int          iready_low = 0;

  // SRAM responder: completes a command lat_cfg cycles after it appears,
  // logging who owned it and what was asked.
  initial begin
    int cnt;
    cnt = 0;
    bus.sram_ready = 1'b0;
    bus.sram_rdata = '0;
    forever begin
      @(negedge clk);
      bus.sram_ready = 1'b0;
      if (bus.sram_r_en && bus.sram_w_en) overlap_n++;
      if (bus.sram_r_en) rd_seen++;
      if (!bus.i_ready) iready_low++;
      if (rst && (bus.sram_r_en || bus.sram_w_en)) begin
        if (cnt >= lat_cfg) begin
          bus.sram_ready = 1'b1;
          bus.sram_rdata = rdata_cfg;
          if (log_n < 64) begin
            log_mem[log_n]   = bus.grant_mem;
            log_wr[log_n]    = bus.sram_w_en;
            log_addr[log_n]  = bus.sram_addr;
            log_wdata[log_n] = bus.sram_wdata;
            log_n++;
          end
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // which: 0 = m_ready, 1 = i_ready, 2 = any sram enable
  task automatic wait_sig(input string tag, input int which, input int max, output int cyc);
    logic hit;
    hit = 1'b0;
    cyc = 0;
    while (!hit && cyc < max) begin
      @(negedge clk);
      cyc++;
      case (which)
        0:       hit = bus.m_ready;
        1:       hit = bus.i_ready;
        2:       hit = bus.sram_r_en | bus.sram_w_en;
        default: hit = 1'b1;
      endcase
    end
    chk(tag, {63'd0, hit}, 64'd1);
  endtask

  initial begin
    int cyc;
    int n0;
    bus.m_r_en  = 1'b0;
    bus.m_w_en  = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.i_r_en  = 1'b0;
    bus.i_addr  = '0;

    // Reset values
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sram_r_en", bus.sram_r_en, 0);
    chk("rst_sram_w_en", bus.sram_w_en, 0);
    chk("rst_sram_addr", bus.sram_addr, 0);
    chk("rst_sram_wdata", bus.sram_wdata, 0);
    chk("rst_m_rdata", bus.m_rdata, 0);
    chk("rst_i_rdata", bus.i_rdata, 0);
    chk("rst_grant_mem", bus.grant_mem, 1);
    chk("rst_m_ready", bus.m_ready, 1);
    chk("rst_i_ready", bus.i_ready, 1);

    // MEM read 0x100, first arbitration right after release
    rst = 1'b1;
    lat_cfg = 3;
    rdata_cfg = 32'hDEAD_BEEF;
    iready_low = 0;
    bus.m_r_en = 1'b1;
    bus.m_addr = 32'h100;
    wait_sig("t1_m_ready_seen", 0, 50, cyc);
    chk("t1_latency", cyc, 5);
    chk("t1_m_rdata", bus.m_rdata, 32'hDEAD_BEEF);
    chk("t1_sram_addr", log_addr[log_n-1], 32'h100);
    chk("t1_grant_mem", bus.grant_mem, 1);
    chk("t1_i_ready_stays", iready_low, 0);
    @(negedge clk);
    chk("t1_ready_one_cycle", bus.m_ready, 0);
    bus.m_r_en = 1'b0;
    @(negedge clk);

    // Simultaneous MEM write and fetch after reset: MEM first
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    lat_cfg = 1;
    rdata_cfg = 32'h1234_5678;
    n0 = log_n;
    bus.m_w_en  = 1'b1;
    bus.m_addr  = 32'h20;
    bus.m_wdata = 32'h55;
    bus.i_r_en  = 1'b1;
    bus.i_addr  = 32'h0;
    wait_sig("t2_m_ready_seen", 0, 50, cyc);
    chk("t2_i_ready_low", bus.i_ready, 0);
    chk("t2_m_rdata_write", bus.m_rdata, 0);
    bus.m_w_en = 1'b0;
    wait_sig("t2_i_ready_seen", 1, 50, cyc);
    chk("t2_i_rdata", bus.i_rdata, 32'h1234_5678);
    bus.i_r_en = 1'b0;
    chk("t2_count", log_n - n0, 2);
    chk("t2_first_mem", log_mem[n0], 1);
    chk("t2_first_wr", log_wr[n0], 1);
    chk("t2_first_addr", log_addr[n0], 32'h20);
    chk("t2_first_wdata", log_wdata[n0], 32'h55);
    chk("t2_second_if", log_mem[n0+1], 0);
    chk("t2_second_rd", log_wr[n0+1], 0);
    chk("t2_second_addr", log_addr[n0+1], 32'h0);
    @(negedge clk);

    // Both request continuously: six alternating grants
    lat_cfg = 0;
    rdata_cfg = 32'hA5A5_0000;
    n0 = log_n;
    bus.m_r_en = 1'b1;
    bus.m_addr = 32'h300;
    bus.i_r_en = 1'b1;
    bus.i_addr = 32'h400;
    cyc = 0;
    while ((log_n - n0) < 6 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    bus.m_r_en = 1'b0;
    bus.i_r_en = 1'b0;
    chk("t3_count", log_n - n0, 6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t3_grant%0d", k), log_mem[n0+k], (k % 2 == 0) ? 64'd1 : 64'd0);
    end
    repeat (3) @(negedge clk);
    chk("t3_m_rdata", bus.m_rdata, 32'hA5A5_0000);
    chk("t3_i_rdata", bus.i_rdata, 32'hA5A5_0000);

    // Fetch withdraws mid-SERVE, then a normal MEM read
    lat_cfg = 3;
    rdata_cfg = 32'hBAD0_BAD0;
    n0 = log_n;
    bus.i_r_en = 1'b1;
    bus.i_addr = 32'h80;
    wait_sig("t4_en_seen", 2, 50, cyc);
    @(negedge clk);
    bus.i_r_en = 1'b0;
    cyc = 0;
    while ((log_n - n0) < 1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    chk("t4_done", log_n - n0, 1);
    chk("t4_owner_if", log_mem[n0], 0);
    chk("t4_addr", log_addr[n0], 32'h80);
    chk("t4_i_rdata_kept", bus.i_rdata, 32'hA5A5_0000);
    chk("t4_i_ready", bus.i_ready, 1);
    lat_cfg = 2;
    rdata_cfg = 32'h0BAD_F00D;
    bus.m_r_en = 1'b1;
    bus.m_addr = 32'h104;
    wait_sig("t4_m_ready_seen", 0, 50, cyc);
    chk("t4_m_rdata", bus.m_rdata, 32'h0BAD_F00D);
    bus.m_r_en = 1'b0;
    @(negedge clk);

    // Reset during SERVE, pending MEM read re-arbitrated afterwards
    lat_cfg = 5;
    rdata_cfg = 32'hCAFE_F00D;
    n0 = log_n;
    bus.m_r_en = 1'b1;
    bus.m_addr = 32'h200;
    wait_sig("t5_en_seen", 2, 50, cyc);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_sram_r_en", bus.sram_r_en, 0);
    chk("t5_sram_w_en", bus.sram_w_en, 0);
    chk("t5_sram_addr", bus.sram_addr, 0);
    chk("t5_m_rdata", bus.m_rdata, 0);
    chk("t5_i_rdata", bus.i_rdata, 0);
    chk("t5_grant_mem", bus.grant_mem, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_sig("t5_m_ready_seen", 0, 50, cyc);
    chk("t5_m_rdata_after", bus.m_rdata, 32'hCAFE_F00D);
    chk("t5_count", log_n - n0, 1);
    chk("t5_addr", log_addr[log_n-1], 32'h200);
    bus.m_r_en = 1'b0;
    @(negedge clk);

    // Read and write together is a write only
    lat_cfg = 1;
    rdata_cfg = 32'h1111_1111;
    rd_seen = 0;
    n0 = log_n;
    bus.m_r_en  = 1'b1;
    bus.m_w_en  = 1'b1;
    bus.m_addr  = 32'h40;
    bus.m_wdata = 32'h77;
    wait_sig("t6_m_ready_seen", 0, 50, cyc);
    chk("t6_m_rdata_kept", bus.m_rdata, 32'hCAFE_F00D);
    bus.m_r_en = 1'b0;
    bus.m_w_en = 1'b0;
    chk("t6_wr", log_wr[n0], 1);
    chk("t6_addr", log_addr[n0], 32'h40);
    chk("t6_wdata", log_wdata[n0], 32'h77);
    chk("t6_no_read", rd_seen, 0);
    repeat (2) @(negedge clk);

    chk("no_overlap", overlap_n, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
